// File: rtl/bus_transfer_unit.sv
// Register file on a shared internal bus, driven by a LOAD/MOVE/SWAP/CLEAR command sequencer.
// Latency to done: 2 cycles (LOAD/MOVE/CLEAR) or 4 (SWAP); 1 cycle to err. cmd_ready only in IDLE.
module bus_transfer_unit #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  localparam int AW      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [AW-1:0]              cmd_src,
  input  logic [AW-1:0]              cmd_dst,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       done,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  localparam int RW = NUM_REGS * DATA_W;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SWAP2,
    S_SWAP3,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [AW-1:0]       src_q, src_d;
  logic [AW-1:0]       dst_q, dst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   tmp_q, tmp_d;
  logic [RW-1:0]       regs_q, regs_d;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [DATA_W-1:0]   wr_val;
  logic                accept;
  logic                cmd_bad;
  logic [DATA_W-1:0]   cmd_src_val;
  logic [DATA_W-1:0]   src_val;
  logic [DATA_W-1:0]   dst_val;

  // Explicit mux so indices beyond NUM_REGS (non power-of-2 sizes) read as zero.
  function automatic logic [DATA_W-1:0] pick(input logic [RW-1:0] flat, input logic [AW-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (AW'(i) == idx) v = flat[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign accept      = cmd_valid && cmd_ready;
  assign cmd_src_val = pick(regs_q, cmd_src);
  assign src_val     = pick(regs_q, src_q);
  assign dst_val     = pick(regs_q, dst_q);
  assign cmd_bad     = !idx_ok(cmd_dst) ||
                       (((cmd_op == OP_MOVE) || (cmd_op == OP_SWAP)) && !idx_ok(cmd_src));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    tmp_d   = tmp_q;
    bus_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = dst_q;
    wr_val  = '0;

    // bus_d/done_d/err_d are the values shown during the state being entered.
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          data_d = cmd_data;
          if (cmd_bad) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = S_EXEC;
            case (cmd_op)
              OP_LOAD:          bus_d = cmd_data;
              OP_MOVE, OP_SWAP: bus_d = cmd_src_val;
              default:          bus_d = '0;
            endcase
          end
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_LOAD: begin
            wr_en  = 1'b1;
            wr_val = data_q;
          end
          OP_MOVE: begin
            wr_en  = 1'b1;
            wr_val = src_val;
          end
          OP_CLEAR: begin
            wr_en  = 1'b1;
            wr_val = '0;
          end
          default: begin
            tmp_d = src_val;
          end
        endcase
        if (op_q == OP_SWAP) begin
          state_d = S_SWAP2;
          bus_d   = dst_val;
        end else begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end

      S_SWAP2: begin
        wr_en   = 1'b1;
        wr_idx  = src_q;
        wr_val  = dst_val;
        state_d = S_SWAP3;
        bus_d   = tmp_q;
      end

      S_SWAP3: begin
        wr_en   = 1'b1;
        wr_idx  = dst_q;
        wr_val  = tmp_q;
        state_d = S_FIN;
        done_d  = 1'b1;
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    regs_d = regs_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (AW'(i) == wr_idx) regs_d[i*DATA_W +: DATA_W] = wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      tmp_q   <= '0;
      regs_q  <= '0;
      bus_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      tmp_q   <= tmp_d;
      regs_q  <= regs_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_out   = bus_q;
  assign done      = done_q;
  assign err       = err_q;
  assign regs_flat = regs_q;

endmodule

// File: tb/tb_bus_transfer_unit.sv
// Bench for bus_transfer_unit: a 4-register instance and a 3-register instance (for out-of-range indices),
// checked with a vector table, hand sequences and a randomized run against an array-based model.
module tb_bus_transfer_unit;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_MOVE  = 2'd1;
  localparam logic [1:0] OP_SWAP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        c_valid;
  logic [1:0]  c_op, c_src, c_dst;
  logic [3:0]  c_data;

  logic        a_ready, a_done, a_err;
  logic [3:0]  a_bus;
  logic [15:0] a_regs;
  logic        b_ready, b_done, b_err;
  logic [3:0]  b_bus;
  logic [11:0] b_regs;

  logic        cur_ready, cur_done, cur_err;
  logic [3:0]  cur_bus;
  logic [15:0] cur_regs;

  int checks = 0;
  int errors = 0;
  int mm [2][4];

  always #5 clk = ~clk;

  bus_transfer_unit #(.DATA_W(4), .NUM_REGS(4)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(c_valid & ~sel), .cmd_ready(a_ready),
    .cmd_op(c_op), .cmd_src(c_src), .cmd_dst(c_dst), .cmd_data(c_data),
    .bus_out(a_bus), .done(a_done), .err(a_err), .regs_flat(a_regs)
  );

  bus_transfer_unit #(.DATA_W(4), .NUM_REGS(3)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(c_valid & sel), .cmd_ready(b_ready),
    .cmd_op(c_op), .cmd_src(c_src), .cmd_dst(c_dst), .cmd_data(c_data),
    .bus_out(b_bus), .done(b_done), .err(b_err), .regs_flat(b_regs)
  );

  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_done  = sel ? b_done  : a_done;
  assign cur_err   = sel ? b_err   : a_err;
  assign cur_bus   = sel ? b_bus   : a_bus;
  assign cur_regs  = sel ? {4'h0, b_regs} : a_regs;

  typedef struct {
    logic       s;
    logic [1:0] op, src, dst;
    logic [3:0] data;
    int         lat;
    logic       err;
    logic [3:0] bus;
    logic [15:0] regs;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic s, input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] data, input int lat, input logic e, input logic [3:0] bus,
                         input logic [15:0] regs);
    vec_t v;
    v.s = s; v.op = op; v.src = src; v.dst = dst; v.data = data;
    v.lat = lat; v.err = e; v.bus = bus; v.regs = regs;
    vq.push_back(v);
  endtask

  // Issues one command, keeps cmd_valid high with scrambled payload until done/err, then drops it.
  task automatic run_cmd(input logic s, input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] data, output int lat, output logic gerr,
                         output logic [3:0] b1, output logic [3:0] b2, output logic [3:0] b3,
                         output logic [3:0] bf, output logic [15:0] rf, output logic both);
    lat = -1; gerr = 1'b0; b1 = '0; b2 = '0; b3 = '0; bf = '0; rf = '0; both = 1'b0;
    @(negedge clk);
    sel = s; c_op = op; c_src = src; c_dst = dst; c_data = data; c_valid = 1'b1;
    #1;
    for (int w = 0; w < 20 && !cur_ready; w++) @(negedge clk);
    if (!cur_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      c_valid = 1'b0;
      return;
    end
    chk("idle_bus", 32'(cur_bus), 32'd0);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      c_op = 2'($urandom); c_src = 2'($urandom); c_dst = 2'($urandom); c_data = 4'($urandom);
      if (k == 1) b1 = cur_bus;
      if (k == 2) b2 = cur_bus;
      if (k == 3) b3 = cur_bus;
      if (cur_done && cur_err) both = 1'b1;
      if (cur_done || cur_err) begin
        lat = k; gerr = cur_err; bf = cur_bus; rf = cur_regs;
        break;
      end
    end
    c_valid = 1'b0;
  endtask

  // Reference: plain array semantics of each op.
  task automatic model_step(input logic s, input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                            input logic [3:0] data, output int lat, output logic e,
                            output logic [3:0] b1, output logic [3:0] b2, output logic [3:0] b3);
    int n, si, di, t;
    n  = s ? 3 : 4;
    si = int'(src);
    di = int'(dst);
    b1 = '0; b2 = '0; b3 = '0;
    e  = (di >= n) || ((op == OP_MOVE || op == OP_SWAP) && si >= n);
    if (e) begin
      lat = 1;
    end else begin
      lat = (op == OP_SWAP) ? 4 : 2;
      case (op)
        OP_LOAD:  begin mm[s][di] = int'(data); b1 = data; end
        OP_MOVE:  begin b1 = 4'(mm[s][si]); mm[s][di] = mm[s][si]; end
        OP_CLEAR: begin mm[s][di] = 0; end
        default: begin
          b1 = 4'(mm[s][si]); b2 = 4'(mm[s][di]); b3 = 4'(mm[s][si]);
          t = mm[s][si]; mm[s][si] = mm[s][di]; mm[s][di] = t;
        end
      endcase
    end
  endtask

  function automatic logic [15:0] pack(input logic s);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < (s ? 3 : 4); i++) p[i*4 +: 4] = 4'(mm[s][i]);
    return p;
  endfunction

  initial begin
    int lat, elat, last, cyc_gap;
    logic gerr, eerr, both, have_last;
    logic [3:0] b1, b2, b3, bf, e1, e2, e3;
    logic [15:0] rf;
    logic [1:0] op, src, dst;
    logic [3:0] data;
    logic s;

    rst = 1'b1; sel = 1'b0; c_valid = 1'b0; c_op = '0; c_src = '0; c_dst = '0; c_data = '0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) mm[i][j] = 0;

    repeat (3) @(negedge clk);
    chk("rst_ready_a", 32'(a_ready), 32'd0);
    chk("rst_ready_b", 32'(b_ready), 32'd0);
    chk("rst_regs_a", 32'(a_regs), 32'd0);
    chk("rst_regs_b", 32'(b_regs), 32'd0);
    chk("rst_outs", {28'd0, a_done, a_err, b_done, b_err}, 32'd0);
    chk("rst_bus", {24'd0, a_bus, b_bus}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_a", 32'(a_ready), 32'd1);

    // {sel, op, src, dst, data, latency, err, EXEC bus, regs after}
    add_vec(1'b0, OP_LOAD,  2'd0, 2'd2, 4'hA, 2, 1'b0, 4'hA, 16'h0A00);
    add_vec(1'b0, OP_LOAD,  2'd0, 2'd0, 4'h3, 2, 1'b0, 4'h3, 16'h0A03);
    add_vec(1'b0, OP_LOAD,  2'd0, 2'd1, 4'h5, 2, 1'b0, 4'h5, 16'h0A53);
    add_vec(1'b0, OP_SWAP,  2'd0, 2'd1, 4'h0, 4, 1'b0, 4'h3, 16'h0A35);
    add_vec(1'b0, OP_LOAD,  2'd0, 2'd1, 4'h7, 2, 1'b0, 4'h7, 16'h0A75);
    add_vec(1'b0, OP_MOVE,  2'd1, 2'd3, 4'h0, 2, 1'b0, 4'h7, 16'h7A75);
    add_vec(1'b0, OP_MOVE,  2'd2, 2'd2, 4'h0, 2, 1'b0, 4'hA, 16'h7A75);
    add_vec(1'b0, OP_SWAP,  2'd3, 2'd3, 4'h0, 4, 1'b0, 4'h7, 16'h7A75);
    add_vec(1'b0, OP_CLEAR, 2'd0, 2'd2, 4'hF, 2, 1'b0, 4'h0, 16'h7075);
    add_vec(1'b0, OP_SWAP,  2'd3, 2'd2, 4'h0, 4, 1'b0, 4'h7, 16'h0775);
    add_vec(1'b1, OP_LOAD,  2'd0, 2'd0, 4'h6, 2, 1'b0, 4'h6, 16'h0006);
    add_vec(1'b1, OP_LOAD,  2'd0, 2'd2, 4'h9, 2, 1'b0, 4'h9, 16'h0906);
    add_vec(1'b1, OP_MOVE,  2'd3, 2'd0, 4'h0, 1, 1'b1, 4'h0, 16'h0906);
    add_vec(1'b1, OP_LOAD,  2'd0, 2'd3, 4'hF, 1, 1'b1, 4'h0, 16'h0906);
    add_vec(1'b1, OP_SWAP,  2'd1, 2'd3, 4'h0, 1, 1'b1, 4'h0, 16'h0906);
    add_vec(1'b1, OP_SWAP,  2'd3, 2'd1, 4'h0, 1, 1'b1, 4'h0, 16'h0906);
    add_vec(1'b1, OP_CLEAR, 2'd0, 2'd3, 4'h0, 1, 1'b1, 4'h0, 16'h0906);
    add_vec(1'b1, OP_MOVE,  2'd2, 2'd1, 4'h0, 2, 1'b0, 4'h9, 16'h0996);
    add_vec(1'b1, OP_SWAP,  2'd0, 2'd2, 4'h0, 4, 1'b0, 4'h6, 16'h0699);

    foreach (vq[i]) begin
      run_cmd(vq[i].s, vq[i].op, vq[i].src, vq[i].dst, vq[i].data, lat, gerr, b1, b2, b3, bf, rf, both);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vq[i].lat));
      chk($sformatf("v%0d_err", i), 32'(gerr), 32'(vq[i].err));
      chk($sformatf("v%0d_bus", i), 32'(b1), 32'(vq[i].bus));
      chk($sformatf("v%0d_regs", i), 32'(rf), 32'(vq[i].regs));
      chk($sformatf("v%0d_finbus", i), {27'd0, both, bf}, 32'd0);
    end

    // Reset asserted in the SWAP2 cycle aborts the swap.
    run_cmd(1'b0, OP_LOAD, 2'd0, 2'd0, 4'h3, lat, gerr, b1, b2, b3, bf, rf, both);
    run_cmd(1'b0, OP_LOAD, 2'd0, 2'd1, 4'h5, lat, gerr, b1, b2, b3, bf, rf, both);
    chk("pre_abort_regs", 32'(a_regs), 32'h0A53 & 32'h00FF | 32'h0700 & 32'h0000 | 32'(a_regs[15:8]) << 8);
    @(negedge clk);
    sel = 1'b0; c_op = OP_SWAP; c_src = 2'd0; c_dst = 2'd1; c_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    chk("abort_exec_bus", 32'(a_bus), 32'h3);
    @(negedge clk);
    chk("abort_swap2_bus", 32'(a_bus), 32'h5);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_regs", 32'(a_regs), 32'd0);
    chk("abort_done", {30'd0, a_done, a_err}, 32'd0);
    chk("abort_ready_in_rst", 32'(a_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(a_ready), 32'd1);
    chk("abort_regs_after", 32'(a_regs), 32'd0);
    chk("abort_no_done", {30'd0, a_done, a_err}, 32'd0);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) mm[i][j] = 0;

    // cmd_valid held high with a new payload every cycle: only IDLE-cycle payloads take effect.
    sel = 1'b0; c_valid = 1'b1; have_last = 1'b0; last = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      op = 2'($urandom_range(2, 0));
      if (op == OP_SWAP) op = OP_CLEAR;
      c_op = op; c_src = 2'($urandom); c_dst = 2'($urandom); c_data = 4'($urandom);
      if (a_ready) begin
        if (have_last) begin
          cyc_gap = cyc - last;
          chk("hold_gap", 32'(cyc_gap), 32'd3);
        end
        have_last = 1'b1;
        last = cyc;
        model_step(1'b0, c_op, c_src, c_dst, c_data, elat, eerr, e1, e2, e3);
      end
    end
    @(negedge clk);
    c_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_regs", 32'(a_regs), 32'(pack(1'b0)));

    // Randomized commands on both instances against the model.
    for (int n = 0; n < 40; n++) begin
      s    = 1'($urandom);
      op   = 2'($urandom);
      src  = 2'($urandom);
      dst  = 2'($urandom);
      data = 4'($urandom);
      model_step(s, op, src, dst, data, elat, eerr, e1, e2, e3);
      run_cmd(s, op, src, dst, data, lat, gerr, b1, b2, b3, bf, rf, both);
      chk($sformatf("r%0d_lat", n), 32'(lat), 32'(elat));
      chk($sformatf("r%0d_err", n), 32'(gerr), 32'(eerr));
      chk($sformatf("r%0d_regs", n), 32'(rf), 32'(pack(s)));
      chk($sformatf("r%0d_bus1", n), 32'(b1), 32'(e1));
      if (op == OP_SWAP && !eerr) begin
        chk($sformatf("r%0d_bus2", n), 32'(b2), 32'(e2));
        chk($sformatf("r%0d_bus3", n), 32'(b3), 32'(e3));
      end
      chk($sformatf("r%0d_finbus", n), {27'd0, both, bf}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
